core_lsu_ctrl: RTL and testbench
================================

Name: core_lsu_ctrl

Overview:
Parametrised load/store unit controller between the EX/MEM pipeline register and the data-memory bus. It accepts one load or store per transaction and computes the effective address, lane strobes, and lane-shifted write data. It issues a single-cycle memory request, waits on the BUSY/DONE handshake with a timeout, and returns the aligned, sign/zero-extended load result. While a transaction is in flight it stalls the pipeline.

Parameters:
DW, 32, memory bus data width in bits (32 or 64); lanes NL = DW/8; offset bits OB = log2(NL)
AW, 32, address width
TMO, 255, WAIT-state cycles without MEM_DONE before error (>=1)

Ports:
CLK  in  1  clock, rising edge
NRST  in  1  asynchronous active-low reset
EX_VALID  in  1  EX/MEM slot holds a valid instruction
ISLOAD  in  1  instruction is a load
ISSTORE  in  1  instruction is a store
FUNCT3  in  3  RV32I width/sign code (LB/LH/LW/LBU/LHU, SB/SH/SW)
BASE  in  32  rs1 value
IMM  in  32  sign-extended offset
WDATA  in  32  rs2 store data
MEM_REQ  out  1  one-cycle request strobe
MEM_WE  out  1  1 = store
MEM_ADDR  out  AW  lane-aligned address (low OB bits zero)
MEM_WDATA  out  DW  lane-shifted store data
MEM_STRB  out  NL  byte-lane enables
MEM_BUSY  in  1  memory accepted request, in progress
MEM_DONE  in  1  one-cycle completion
MEM_RDATA  in  DW  read data, valid with MEM_DONE
STALL  out  1  hold pipeline
LD_DATA  out  32  extended load result
LD_VALID  out  1  one-cycle result/complete pulse (loads and stores)
ERR  out  1  one-cycle bus timeout / misalign flag, coincident with LD_VALID

Behaviour:
- Reset (NRST low, async): state IDLE, timeout counter 0, all outputs 0. Reset asserted mid-transaction aborts it and emits no LD_VALID.
- EA = BASE + IMM, truncated to AW. off = EA[OB-1:0].
- Size from FUNCT3[1:0]: 00 byte (1 lane), 01 half (2 lanes), 10 word (4 lanes). Strobe = size mask << off.
- MEM_WDATA = WDATA replicated to DW, then shifted left by 8*off.
- States:
  - IDLE: accept when EX_VALID & (ISLOAD|ISSTORE). Latch EA, strobe, funct3, wdata, WE. STALL is driven high combinationally in the accept cycle. Go to REQ. ISLOAD and ISSTORE both high: load wins.
  - REQ: MEM_REQ=1 for exactly this cycle, with MEM_ADDR/MEM_WE/MEM_STRB/MEM_WDATA stable. If MEM_DONE is already high (zero-wait memory), go to RESP; otherwise go to WAIT. Address, strobe and data outputs stay stable until RESP exits.
  - WAIT: count cycles. On MEM_DONE, capture MEM_RDATA and go to RESP. If the count reaches TMO without MEM_DONE, set ERR and go to RESP. MEM_BUSY is informational only; MEM_REQ is never re-issued.
  - RESP: LD_VALID=1 for one cycle, STALL=0, ERR as latched. Return to IDLE. A new request may not be accepted in RESP; the earliest accept is the following cycle, so back-to-back transactions are 3 cycles apart minimum.
- Load extract: shift the captured rdata right by 8*off. LB/LH sign-extend bit 7/15. LBU/LHU zero-extend. LW passes through. Stores and errors give LD_DATA=0.
- An access crossing an NL-lane boundary (off+size > NL) is misaligned. Handling is set by the optional feature below.
- STALL = accept | (state in REQ, WAIT).

Optional Feature:
CORE_LSU_MISALIGN_TRAP_EN.
- Defined: a misaligned access does not enter REQ. It goes directly IDLE→RESP with ERR=1, LD_DATA=0, and MEM_REQ never asserts.
- Undefined: the access is forced to natural alignment (off aligned down to size). The request is issued normally and ERR reflects only timeout.

Test Plan:
- DW=32, LW with BASE=0x100, IMM=4, rdata 0xDEADBEEF, DONE 2 cycles after REQ -> MEM_ADDR=0x104, STRB=1111, LD_DATA=0xDEADBEEF, LD_VALID one cycle, STALL high for 4 cycles.
- LB with EA=0x103, rdata 0x80000000 -> STRB=1000, LD_DATA=0xFFFFFF80. Same access as LBU -> 0x00000080.
- SH with EA=0x202, WDATA=0x0000ABCD, DW=64 -> MEM_ADDR=0x200, STRB=0x0C, MEM_WDATA lanes[3:2]=0xABCD, MEM_WE=1.
- MEM_DONE high in the REQ cycle -> RESP next cycle, no WAIT, total STALL 2 cycles.
- No MEM_DONE, TMO=4 -> ERR and LD_VALID together 4 cycles into WAIT, LD_DATA=0, then IDLE. Reset pulsed mid-WAIT in a separate run -> all outputs 0 immediately, no LD_VALID.
- LW at EA=0x101: with the macro defined -> ERR=1, no MEM_REQ. Without the macro -> MEM_ADDR=0x100, STRB=1111, ERR=0.

Source files
------------

// File: rtl/core_lsu_ctrl.sv
// core_lsu_ctrl
//    Load/store unit controller that sits between the EX/MEM pipeline
//    register and the data-memory bus. One load or store is taken per
//    transaction: the effective address, byte-lane strobes and lane-shifted
//    store data are computed and latched, a single-cycle MEM_REQ is issued,
//    the BUSY/DONE handshake is awaited (with a timeout), and the load
//    result is returned aligned and sign/zero-extended. The pipeline is
//    stalled while a transaction is in flight.
//
//    Parameters
//       DW  : memory bus data width (32 or 64), NL = DW/8 byte lanes
//       AW  : address width
//       TMO : WAIT cycles without MEM_DONE before a timeout error (>= 1)
//
//    Ports
//       CLK, NRST              : rising-edge clock, async active-low reset
//       EX_VALID, ISLOAD,
//       ISSTORE, FUNCT3        : instruction slot and RV32I width/sign code
//       BASE, IMM, WDATA       : rs1, sign-extended offset, rs2 store data
//       MEM_REQ/WE/ADDR/WDATA/STRB : memory request side
//       MEM_BUSY/DONE/RDATA    : memory response side (BUSY is informational)
//       STALL                  : hold the pipeline
//       LD_DATA, LD_VALID, ERR : result, completion pulse, timeout/misalign
//
//    Build option
//       CORE_LSU_MISALIGN_TRAP_EN : when defined, an access that crosses an
//       NL-lane boundary completes at once with ERR and never reaches the bus.
//       When undefined, such an access is forced down to natural alignment.

module core_lsu_ctrl #(
   parameter int DW  = 32,
   parameter int AW  = 32,
   parameter int TMO = 255
) (
   input  logic            CLK,
   input  logic            NRST,
   input  logic            EX_VALID,
   input  logic            ISLOAD,
   input  logic            ISSTORE,
   input  logic [2:0]      FUNCT3,
   input  logic [31:0]     BASE,
   input  logic [31:0]     IMM,
   input  logic [31:0]     WDATA,
   output logic            MEM_REQ,
   output logic            MEM_WE,
   output logic [AW-1:0]   MEM_ADDR,
   output logic [DW-1:0]   MEM_WDATA,
   output logic [DW/8-1:0] MEM_STRB,
   input  logic            MEM_BUSY,
   input  logic            MEM_DONE,
   input  logic [DW-1:0]   MEM_RDATA,
   output logic            STALL,
   output logic [31:0]     LD_DATA,
   output logic            LD_VALID,
   output logic            ERR
);

   localparam int NL = DW / 8;
   localparam int OB = $clog2(NL);
   localparam int CW = (TMO < 2) ? 1 : $clog2(TMO);

   typedef enum logic [1:0] {
      S_IDLE,
      S_REQ,
      S_WAIT,
      S_RESP
   } stateT;

   stateT           stateQ, stateD;
   logic [CW-1:0]   cntQ, cntD;
   logic [AW-1:0]   addrQ, addrD;
   logic [NL-1:0]   strbQ, strbD;
   logic [DW-1:0]   wdataQ, wdataD;
   logic [DW-1:0]   rdataQ, rdataD;
   logic [OB-1:0]   offQ, offD;
   logic [2:0]      funct3Q, funct3D;
   logic            weQ, weD;
   logic            errQ, errD;

   logic [31:0]     eaFull;
   logic [AW-1:0]   ea;
   logic [OB-1:0]   offRaw;
   logic [OB-1:0]   offUse;
   logic [NL-1:0]   sizeMask;
   logic [NL-1:0]   strbNew;
   logic [DW-1:0]   wdataNew;
   logic [AW-1:0]   addrNew;
   int              sizeBytes;
   logic            misaligned;
   logic            accept;
   logic [31:0]     loadShifted;

   // Decode the incoming instruction into what the bus will see: the
   // effective address, the lane offset inside the bus word, the strobe
   // pattern and the store data moved onto its lanes. An access is
   // misaligned when its bytes would spill past the last lane; without the
   // trap build the offset is rounded down to the access size so the
   // request stays inside one bus word.
   always_comb begin
      eaFull    = BASE + IMM;
      ea        = AW'(eaFull);
      offRaw    = ea[OB-1:0];
      sizeMask  = NL'(4'hF);
      sizeBytes = 4;
      case (FUNCT3[1:0])
         2'b00: begin
            sizeMask  = NL'(1);
            sizeBytes = 1;
         end
         2'b01: begin
            sizeMask  = NL'(3);
            sizeBytes = 2;
         end
         default: ;
      endcase
      misaligned = (int'(offRaw) + sizeBytes) > NL;
`ifdef CORE_LSU_MISALIGN_TRAP_EN
      offUse = offRaw;
`else
      offUse = misaligned ? (offRaw & ~OB'(sizeBytes - 1)) : offRaw;
`endif
      strbNew  = sizeMask << offUse;
      wdataNew = {(DW/32){WDATA}} << {offUse, 3'b000};
      addrNew  = {ea[AW-1:OB], OB'(0)};
   end

   // A transaction is taken only from IDLE. Reset is folded in so that the
   // combinational STALL stays low while the block is held in reset.
   always_comb begin
      accept = NRST & (stateQ == S_IDLE) & EX_VALID & (ISLOAD | ISSTORE);
   end

   // Next-state logic. Everything the bus sees is latched on accept and
   // held until the transaction has finished, so the memory can sample it
   // any time during REQ or WAIT. The timeout counter only runs in WAIT and
   // a pending MEM_DONE always beats the timeout in the same cycle. The
   // request is never re-issued; MEM_BUSY carries no control meaning here.
   always_comb begin
      stateD  = stateQ;
      cntD    = cntQ;
      addrD   = addrQ;
      strbD   = strbQ;
      wdataD  = wdataQ;
      rdataD  = rdataQ;
      offD    = offQ;
      funct3D = funct3Q;
      weD     = weQ;
      errD    = errQ;
      case (stateQ)
         S_IDLE: begin
            if (accept) begin
               addrD   = addrNew;
               strbD   = strbNew;
               wdataD  = wdataNew;
               offD    = offUse;
               funct3D = FUNCT3;
               weD     = ~ISLOAD;
               rdataD  = '0;
               cntD    = '0;
               errD    = 1'b0;
               stateD  = S_REQ;
`ifdef CORE_LSU_MISALIGN_TRAP_EN
               if (misaligned) begin
                  errD   = 1'b1;
                  stateD = S_RESP;
               end
`endif
            end
         end
         S_REQ: begin
            cntD = '0;
            if (MEM_DONE) begin
               rdataD = MEM_RDATA;
               stateD = S_RESP;
            end else begin
               stateD = S_WAIT;
            end
         end
         S_WAIT: begin
            if (MEM_DONE) begin
               rdataD = MEM_RDATA;
               stateD = S_RESP;
            end else if (cntQ == CW'(TMO - 1)) begin
               errD   = 1'b1;
               stateD = S_RESP;
            end else begin
               cntD = cntQ + 1'b1;
            end
         end
         S_RESP: begin
            stateD = S_IDLE;
         end
         default: begin
            stateD = S_IDLE;
         end
      endcase
   end

   // State and transaction registers. An asynchronous reset drops any
   // transaction in flight, so no completion pulse follows it.
   always_ff @(posedge CLK or negedge NRST) begin
      if (!NRST) begin
         stateQ  <= S_IDLE;
         cntQ    <= '0;
         addrQ   <= '0;
         strbQ   <= '0;
         wdataQ  <= '0;
         rdataQ  <= '0;
         offQ    <= '0;
         funct3Q <= '0;
         weQ     <= 1'b0;
         errQ    <= 1'b0;
      end else begin
         stateQ  <= stateD;
         cntQ    <= cntD;
         addrQ   <= addrD;
         strbQ   <= strbD;
         wdataQ  <= wdataD;
         rdataQ  <= rdataD;
         offQ    <= offD;
         funct3Q <= funct3D;
         weQ     <= weD;
         errQ    <= errD;
      end
   end

   // Output decode. The load result is produced only in RESP: the captured
   // bus word is shifted so the addressed byte sits in bit 0, then sign- or
   // zero-extended by the RV32I width code. Stores and errored accesses
   // return zero.
   always_comb begin
      MEM_REQ     = (stateQ == S_REQ);
      MEM_WE      = weQ;
      MEM_ADDR    = addrQ;
      MEM_WDATA   = wdataQ;
      MEM_STRB    = strbQ;
      STALL       = accept | (stateQ == S_REQ) | (stateQ == S_WAIT);
      LD_VALID    = (stateQ == S_RESP);
      ERR         = (stateQ == S_RESP) & errQ;
      loadShifted = 32'(rdataQ >> {offQ, 3'b000});
      LD_DATA     = '0;
      if ((stateQ == S_RESP) && !weQ && !errQ) begin
         case (funct3Q)
            3'b000:  LD_DATA = {{24{loadShifted[7]}}, loadShifted[7:0]};
            3'b001:  LD_DATA = {{16{loadShifted[15]}}, loadShifted[15:0]};
            3'b010:  LD_DATA = loadShifted;
            3'b100:  LD_DATA = {24'h0, loadShifted[7:0]};
            3'b101:  LD_DATA = {16'h0, loadShifted[15:0]};
            default: LD_DATA = '0;
         endcase
      end
   end

endmodule

// File: tb/tb_core_lsu_ctrl.sv
// tb_core_lsu_ctrl
//    Directed bench for core_lsu_ctrl. A 32-bit and a 64-bit bus instance
//    share all stimulus; each scenario task drives one transaction (or a
//    sequence) and compares the observed bus/result values against
//    hand-computed constants. Both instances use a timeout of 4 cycles.

module tb_core_lsu_ctrl;

   logic        CLK;
   logic        NRST;
   logic        EX_VALID;
   logic        ISLOAD;
   logic        ISSTORE;
   logic [2:0]  FUNCT3;
   logic [31:0] BASE;
   logic [31:0] IMM;
   logic [31:0] WDATA;
   logic        MEM_BUSY;
   logic        MEM_DONE;
   logic [31:0] rdataDrv;

   logic        memReq32, memWe32, stall32, ldValid32, err32;
   logic [31:0] memAddr32, memWdata32, ldData32;
   logic [3:0]  memStrb32;
   logic        memReq64, memWe64, stall64, ldValid64, err64;
   logic [31:0] memAddr64, ldData64;
   logic [63:0] memWdata64;
   logic [7:0]  memStrb64;

   int          compareCount;
   int          mismatchCount;

   int          stallCount, reqCount, reqIdx, validCount, validIdx;
   logic [31:0] capAddr, capWdata, capLd, respAddr;
   logic [3:0]  capStrb;
   logic        capWe, capErr;
   logic [31:0] capAddr64;
   logic [63:0] capWdata64;
   logic [7:0]  capStrb64;
   logic        capWe64, got64;

   core_lsu_ctrl #(.DW(32), .AW(32), .TMO(4)) dut32 (
      .CLK(CLK), .NRST(NRST), .EX_VALID(EX_VALID), .ISLOAD(ISLOAD),
      .ISSTORE(ISSTORE), .FUNCT3(FUNCT3), .BASE(BASE), .IMM(IMM),
      .WDATA(WDATA), .MEM_REQ(memReq32), .MEM_WE(memWe32),
      .MEM_ADDR(memAddr32), .MEM_WDATA(memWdata32), .MEM_STRB(memStrb32),
      .MEM_BUSY(MEM_BUSY), .MEM_DONE(MEM_DONE), .MEM_RDATA(rdataDrv),
      .STALL(stall32), .LD_DATA(ldData32), .LD_VALID(ldValid32), .ERR(err32)
   );

   core_lsu_ctrl #(.DW(64), .AW(32), .TMO(4)) dut64 (
      .CLK(CLK), .NRST(NRST), .EX_VALID(EX_VALID), .ISLOAD(ISLOAD),
      .ISSTORE(ISSTORE), .FUNCT3(FUNCT3), .BASE(BASE), .IMM(IMM),
      .WDATA(WDATA), .MEM_REQ(memReq64), .MEM_WE(memWe64),
      .MEM_ADDR(memAddr64), .MEM_WDATA(memWdata64), .MEM_STRB(memStrb64),
      .MEM_BUSY(MEM_BUSY), .MEM_DONE(MEM_DONE), .MEM_RDATA({rdataDrv, rdataDrv}),
      .STALL(stall64), .LD_DATA(ldData64), .LD_VALID(ldValid64), .ERR(err64)
   );

   // Free-running 100 MHz clock
   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   // Drive one transaction: present it for a single cycle, then watch a
   // fixed window of 12 cycles. MEM_DONE is raised doneDelay cycles after
   // the 32-bit instance's request (never when doneDelay is negative).
   // Everything interesting is recorded for the scenario task to compare.
   task automatic applyStimulus(input logic isLoad, input logic isStore,
                                input logic [2:0] f3, input logic [31:0] base,
                                input logic [31:0] imm, input logic [31:0] wd,
                                input logic [31:0] rd, input int doneDelay);
      stallCount = 0; reqCount = 0; reqIdx = -1; validCount = 0; validIdx = -1;
      capAddr = '0; capWdata = '0; capLd = '0; respAddr = '0; capStrb = '0;
      capWe = 1'b0; capErr = 1'b0; got64 = 1'b0;
      capAddr64 = '0; capWdata64 = '0; capStrb64 = '0; capWe64 = 1'b0;
      @(negedge CLK);
      EX_VALID = 1'b1; ISLOAD = isLoad; ISSTORE = isStore; FUNCT3 = f3;
      BASE = base; IMM = imm; WDATA = wd; rdataDrv = rd; MEM_DONE = 1'b0;
      #1;
      if (stall32) stallCount++;
      for (int i = 0; i < 12; i++) begin
         @(negedge CLK);
         EX_VALID = 1'b0; ISLOAD = 1'b0; ISSTORE = 1'b0;
         #1;
         if (stall32) stallCount++;
         if (memReq32) begin
            reqCount++;
            if (reqIdx < 0) begin
               reqIdx = i; capAddr = memAddr32; capStrb = memStrb32;
               capWdata = memWdata32; capWe = memWe32;
            end
         end
         if (memReq64 && !got64) begin
            got64 = 1'b1; capAddr64 = memAddr64; capStrb64 = memStrb64;
            capWdata64 = memWdata64; capWe64 = memWe64;
         end
         if (ldValid32) begin
            validCount++; validIdx = i; capLd = ldData32; capErr = err32;
            respAddr = memAddr32;
         end
         MEM_DONE = (doneDelay >= 0) && (reqIdx >= 0) && (i == reqIdx + doneDelay);
      end
      MEM_DONE = 1'b0;
   endtask

   // Reset holds every output low, even with a request presented
   task automatic test_reset();
      NRST = 1'b0; EX_VALID = 1'b1; ISLOAD = 1'b1; ISSTORE = 1'b0;
      FUNCT3 = 3'b010; BASE = 32'h100; IMM = 32'h4; WDATA = 32'h1234_5678;
      repeat (2) @(negedge CLK);
      #1;
      compareCount++; if (stall32 !== 1'b0) begin mismatchCount++; $display("[TB] FAIL reset_stall: got %b expected 0", stall32); end
      compareCount++; if (memReq32 !== 1'b0) begin mismatchCount++; $display("[TB] FAIL reset_req: got %b expected 0", memReq32); end
      compareCount++; if ({ldValid32, err32, ldData32} !== 34'h0) begin mismatchCount++; $display("[TB] FAIL reset_result: got %h expected 0", {ldValid32, err32, ldData32}); end
      compareCount++; if ({memWe32, memAddr32, memStrb32, memWdata32} !== 69'h0) begin mismatchCount++; $display("[TB] FAIL reset_bus: got %h expected 0", {memWe32, memAddr32, memStrb32, memWdata32}); end
      EX_VALID = 1'b0; ISLOAD = 1'b0;
      @(negedge CLK);
      NRST = 1'b1;
   endtask

   // LW with two wait cycles on the bus
   task automatic test_load_word();
      applyStimulus(1'b1, 1'b0, 3'b010, 32'h100, 32'h4, 32'h0, 32'hDEAD_BEEF, 2);
      compareCount++; if (capAddr !== 32'h104) begin mismatchCount++; $display("[TB] FAIL lw_addr: got %h expected %h", capAddr, 32'h104); end
      compareCount++; if (capStrb !== 4'hF) begin mismatchCount++; $display("[TB] FAIL lw_strb: got %h expected f", capStrb); end
      compareCount++; if (capWe !== 1'b0) begin mismatchCount++; $display("[TB] FAIL lw_we: got %b expected 0", capWe); end
      compareCount++; if (capLd !== 32'hDEAD_BEEF) begin mismatchCount++; $display("[TB] FAIL lw_data: got %h expected deadbeef", capLd); end
      compareCount++; if (validCount !== 1) begin mismatchCount++; $display("[TB] FAIL lw_valid_count: got %0d expected 1", validCount); end
      compareCount++; if (validIdx !== 3) begin mismatchCount++; $display("[TB] FAIL lw_valid_cycle: got %0d expected 3", validIdx); end
      compareCount++; if (stallCount !== 4) begin mismatchCount++; $display("[TB] FAIL lw_stall_cycles: got %0d expected 4", stallCount); end
      compareCount++; if (reqCount !== 1) begin mismatchCount++; $display("[TB] FAIL lw_req_count: got %0d expected 1", reqCount); end
      compareCount++; if (capErr !== 1'b0) begin mismatchCount++; $display("[TB] FAIL lw_err: got %b expected 0", capErr); end
      compareCount++; if (respAddr !== 32'h104) begin mismatchCount++; $display("[TB] FAIL lw_addr_hold: got %h expected %h", respAddr, 32'h104); end
      compareCount++; if ({capAddr64, capStrb64} !== {32'h100, 8'hF0}) begin mismatchCount++; $display("[TB] FAIL lw64_addr_strb: got %h expected %h", {capAddr64, capStrb64}, {32'h100, 8'hF0}); end
   endtask

   // LB and LBU of the top byte lane
   task automatic test_load_byte();
      applyStimulus(1'b1, 1'b0, 3'b000, 32'h100, 32'h3, 32'h0, 32'h8000_0000, 1);
      compareCount++; if (capStrb !== 4'h8) begin mismatchCount++; $display("[TB] FAIL lb_strb: got %h expected 8", capStrb); end
      compareCount++; if (capAddr !== 32'h100) begin mismatchCount++; $display("[TB] FAIL lb_addr: got %h expected 100", capAddr); end
      compareCount++; if (capLd !== 32'hFFFF_FF80) begin mismatchCount++; $display("[TB] FAIL lb_data: got %h expected ffffff80", capLd); end
      applyStimulus(1'b1, 1'b0, 3'b100, 32'h100, 32'h3, 32'h0, 32'h8000_0000, 1);
      compareCount++; if (capLd !== 32'h0000_0080) begin mismatchCount++; $display("[TB] FAIL lbu_data: got %h expected 00000080", capLd); end
   endtask

   // LH and LHU at the upper half, reached through a negative offset
   task automatic test_load_half();
      applyStimulus(1'b1, 1'b0, 3'b001, 32'h10A, 32'hFFFF_FFFC, 32'h0, 32'h8001_1234, 1);
      compareCount++; if (capAddr !== 32'h104) begin mismatchCount++; $display("[TB] FAIL lh_addr: got %h expected 104", capAddr); end
      compareCount++; if (capStrb !== 4'hC) begin mismatchCount++; $display("[TB] FAIL lh_strb: got %h expected c", capStrb); end
      compareCount++; if (capLd !== 32'hFFFF_8001) begin mismatchCount++; $display("[TB] FAIL lh_data: got %h expected ffff8001", capLd); end
      applyStimulus(1'b1, 1'b0, 3'b101, 32'h10A, 32'hFFFF_FFFC, 32'h0, 32'h8001_1234, 1);
      compareCount++; if (capLd !== 32'h0000_8001) begin mismatchCount++; $display("[TB] FAIL lhu_data: got %h expected 00008001", capLd); end
   endtask

   // SH on both bus widths: lane shifting, strobes and write enable
   task automatic test_store_half();
      applyStimulus(1'b0, 1'b1, 3'b001, 32'h200, 32'h2, 32'h0000_ABCD, 32'hFFFF_FFFF, 1);
      compareCount++; if (capAddr64 !== 32'h200) begin mismatchCount++; $display("[TB] FAIL sh64_addr: got %h expected 200", capAddr64); end
      compareCount++; if (capStrb64 !== 8'h0C) begin mismatchCount++; $display("[TB] FAIL sh64_strb: got %h expected 0c", capStrb64); end
      compareCount++; if (capWdata64 !== 64'hABCD_0000_ABCD_0000) begin mismatchCount++; $display("[TB] FAIL sh64_wdata: got %h expected abcd0000abcd0000", capWdata64); end
      compareCount++; if (capWe64 !== 1'b1) begin mismatchCount++; $display("[TB] FAIL sh64_we: got %b expected 1", capWe64); end
      compareCount++; if (capWdata !== 32'hABCD_0000) begin mismatchCount++; $display("[TB] FAIL sh32_wdata: got %h expected abcd0000", capWdata); end
      compareCount++; if ({capWe, capStrb} !== 5'h1C) begin mismatchCount++; $display("[TB] FAIL sh32_we_strb: got %h expected 1c", {capWe, capStrb}); end
      compareCount++; if (capLd !== 32'h0) begin mismatchCount++; $display("[TB] FAIL sh_lddata: got %h expected 0", capLd); end
      compareCount++; if (validCount !== 1) begin mismatchCount++; $display("[TB] FAIL sh_valid_count: got %0d expected 1", validCount); end
   endtask

   // Zero-wait memory: DONE already high during the request cycle
   task automatic test_zero_wait();
      applyStimulus(1'b1, 1'b0, 3'b010, 32'h300, 32'h0, 32'h0, 32'h1234_5678, 0);
      compareCount++; if (stallCount !== 2) begin mismatchCount++; $display("[TB] FAIL zw_stall_cycles: got %0d expected 2", stallCount); end
      compareCount++; if (validIdx !== 1) begin mismatchCount++; $display("[TB] FAIL zw_valid_cycle: got %0d expected 1", validIdx); end
      compareCount++; if (capLd !== 32'h1234_5678) begin mismatchCount++; $display("[TB] FAIL zw_data: got %h expected 12345678", capLd); end
   endtask

   // Both ISLOAD and ISSTORE high: the load wins
   task automatic test_load_wins();
      applyStimulus(1'b1, 1'b1, 3'b010, 32'h40, 32'h0, 32'hFFFF_FFFF, 32'h0BAD_CAFE, 1);
      compareCount++; if (capWe !== 1'b0) begin mismatchCount++; $display("[TB] FAIL lwins_we: got %b expected 0", capWe); end
      compareCount++; if (capLd !== 32'h0BAD_CAFE) begin mismatchCount++; $display("[TB] FAIL lwins_data: got %h expected 0badcafe", capLd); end
   endtask

   // No MEM_DONE at all: timeout after 4 WAIT cycles
   task automatic test_timeout();
      applyStimulus(1'b1, 1'b0, 3'b010, 32'h400, 32'h0, 32'h0, 32'h5555_5555, -1);
      compareCount++; if (capErr !== 1'b1) begin mismatchCount++; $display("[TB] FAIL tmo_err: got %b expected 1", capErr); end
      compareCount++; if (validIdx !== 5) begin mismatchCount++; $display("[TB] FAIL tmo_valid_cycle: got %0d expected 5", validIdx); end
      compareCount++; if (capLd !== 32'h0) begin mismatchCount++; $display("[TB] FAIL tmo_data: got %h expected 0", capLd); end
      compareCount++; if (reqCount !== 1) begin mismatchCount++; $display("[TB] FAIL tmo_req_count: got %0d expected 1", reqCount); end
      compareCount++; if (stall32 !== 1'b0) begin mismatchCount++; $display("[TB] FAIL tmo_idle_stall: got %b expected 0", stall32); end
   endtask

   // Reset pulsed while waiting on the bus: aborts with no completion
   task automatic test_reset_mid_wait();
      int pulses;
      pulses = 0;
      @(negedge CLK);
      EX_VALID = 1'b1; ISLOAD = 1'b1; FUNCT3 = 3'b010; BASE = 32'h600; IMM = 32'h0;
      MEM_DONE = 1'b0;
      repeat (3) begin
         @(negedge CLK);
         EX_VALID = 1'b0; ISLOAD = 1'b0;
      end
      #1;
      compareCount++; if (stall32 !== 1'b1) begin mismatchCount++; $display("[TB] FAIL rmw_pre_stall: got %b expected 1", stall32); end
      NRST = 1'b0;
      #1;
      compareCount++; if ({stall32, memReq32, ldValid32, err32} !== 4'b0) begin mismatchCount++; $display("[TB] FAIL rmw_ctrl: got %b expected 0000", {stall32, memReq32, ldValid32, err32}); end
      compareCount++; if ({memAddr32, memStrb32, ldData32} !== 68'h0) begin mismatchCount++; $display("[TB] FAIL rmw_data: got %h expected 0", {memAddr32, memStrb32, ldData32}); end
      @(negedge CLK);
      NRST = 1'b1;
      for (int i = 0; i < 8; i++) begin
         @(negedge CLK);
         MEM_DONE = (i == 1);
         #1;
         if (ldValid32) pulses++;
      end
      MEM_DONE = 1'b0;
      compareCount++; if (pulses !== 0) begin mismatchCount++; $display("[TB] FAIL rmw_no_valid: got %0d expected 0", pulses); end
   endtask

   // LW at EA 0x101 crosses the 32-bit word boundary
   task automatic test_misalign();
      applyStimulus(1'b1, 1'b0, 3'b010, 32'h100, 32'h1, 32'h0, 32'hCAFE_F00D, 1);
`ifdef CORE_LSU_MISALIGN_TRAP_EN
      compareCount++; if (reqCount !== 0) begin mismatchCount++; $display("[TB] FAIL mis_req_count: got %0d expected 0", reqCount); end
      compareCount++; if (capErr !== 1'b1) begin mismatchCount++; $display("[TB] FAIL mis_err: got %b expected 1", capErr); end
      compareCount++; if (validIdx !== 0) begin mismatchCount++; $display("[TB] FAIL mis_valid_cycle: got %0d expected 0", validIdx); end
      compareCount++; if (capLd !== 32'h0) begin mismatchCount++; $display("[TB] FAIL mis_data: got %h expected 0", capLd); end
`else
      compareCount++; if (capAddr !== 32'h100) begin mismatchCount++; $display("[TB] FAIL mis_addr: got %h expected 100", capAddr); end
      compareCount++; if (capStrb !== 4'hF) begin mismatchCount++; $display("[TB] FAIL mis_strb: got %h expected f", capStrb); end
      compareCount++; if (capErr !== 1'b0) begin mismatchCount++; $display("[TB] FAIL mis_err: got %b expected 0", capErr); end
      compareCount++; if (capLd !== 32'hCAFE_F00D) begin mismatchCount++; $display("[TB] FAIL mis_data: got %h expected cafef00d", capLd); end
`endif
   endtask

   // Request held continuously with a zero-wait memory: requests land
   // every third cycle because RESP cannot accept
   task automatic test_back_to_back();
      int reqs, valids, firstReq, secondReq;
      reqs = 0; valids = 0; firstReq = -1; secondReq = -1;
      @(negedge CLK);
      EX_VALID = 1'b1; ISLOAD = 1'b1; ISSTORE = 1'b0; FUNCT3 = 3'b010;
      BASE = 32'h500; IMM = 32'h0; rdataDrv = 32'h7777_0001; MEM_DONE = 1'b1;
      for (int i = 0; i < 8; i++) begin
         @(negedge CLK);
         #1;
         if (memReq32) begin
            reqs++;
            if (firstReq < 0) firstReq = i;
            else if (secondReq < 0) secondReq = i;
         end
         if (ldValid32) valids++;
      end
      EX_VALID = 1'b0; ISLOAD = 1'b0; MEM_DONE = 1'b0;
      repeat (3) @(negedge CLK);
      compareCount++; if (reqs !== 3) begin mismatchCount++; $display("[TB] FAIL b2b_req_count: got %0d expected 3", reqs); end
      compareCount++; if (secondReq - firstReq !== 3) begin mismatchCount++; $display("[TB] FAIL b2b_spacing: got %0d expected 3", secondReq - firstReq); end
      compareCount++; if (valids !== 3) begin mismatchCount++; $display("[TB] FAIL b2b_valid_count: got %0d expected 3", valids); end
   endtask

   // Scenario sequence and summary
   initial begin
      compareCount = 0; mismatchCount = 0;
      NRST = 1'b0; EX_VALID = 1'b0; ISLOAD = 1'b0; ISSTORE = 1'b0;
      FUNCT3 = 3'b000; BASE = '0; IMM = '0; WDATA = '0;
      MEM_BUSY = 1'b0; MEM_DONE = 1'b0; rdataDrv = '0;
      $display("[TB] core_lsu_ctrl directed bench start");
      test_reset();
      test_load_word();
      test_load_byte();
      test_load_half();
      test_store_half();
      test_zero_wait();
      test_load_wins();
      test_timeout();
      test_reset_mid_wait();
      test_misalign();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
      $finish;
   end

endmodule
